// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - operation encodings as seen on the op port
//   - FSM state encoding
//   - default operand width and fixed start-to-done latency
//   - small helpers classifying an operation
package muldiv_pkg;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 34;   // cycles from accepting edge to done cycle

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: handshake and HI/LO bus between pipeline control and the
// multiply/divide unit.
//   master (pipeline): drives start/op/op_a/op_b/hi_we/lo_we/wdata,
//                      observes busy/done/div_by_zero/hi/lo
//   slave  (unit)    : the reverse
interface muldiv_unit_if #(
    parameter int WIDTH = muldiv_pkg::WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   acc_hi_i/acc_lo_i : current accumulator (upper WIDTH+1 bits, lower WIDTH)
//   opnd_i            : multiplicand magnitude (mul) or divisor magnitude (div)
//   div_i             : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_hi_o/acc_lo_o : next accumulator
// Multiply: acc = {partial product, remaining multiplier bits}; add opnd when
// the multiplier LSB is set, then shift the whole thing right by one.
// Divide:   acc = {remainder, dividend/quotient bits}; shift left by one,
// trial subtract the divisor, keep it and shift in a 1 when no borrow.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             div_i,
    output logic [WIDTH:0]   acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   add_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;

    always_comb begin
        add_op = acc_lo_i[0] ? {1'b0, opnd_i} : '0;
        sum    = acc_hi_i + add_op;
        rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
        trial  = rem_sh - {2'b00, opnd_i};

        if (div_i) begin
            // top bit of trial is the borrow of the trial subtraction
            if (!trial[WIDTH+1]) begin
                acc_hi_o = trial[WIDTH:0];
                acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_o = rem_sh[WIDTH:0];
                acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_o = {1'b0, sum[WIDTH:1]};
            acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : muldiv_unit_if.slave (start/op/operands, MTHI/MTLO writes,
//           busy/done/div_by_zero status, HI/LO)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, MTHI/MTLO allowed
// CALC    | one shift-add / restoring-divide iteration per cycle, WIDTH cycles
// SIGN    | sign fix-up / divide-by-zero override, HI/LO written
// DONE    | done pulse, results visible, start accepted back-to-back
module muldiv_unit #(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_unit_if.slave bus
);
    import muldiv_pkg::*;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    op_e                op_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [WIDTH:0]     acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    // operand conditioning at accept
    op_e                op_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // datapath step and sign fix-up
    logic [WIDTH:0]     acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_d;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    always_comb begin
        op_in = op_e'(bus.op);
        a_neg = op_is_signed(op_in) & bus.op_a[WIDTH-1];
        b_neg = op_is_signed(op_in) & bus.op_b[WIDTH-1];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
        mag_a = a_neg ? -bus.op_a : bus.op_a;
        mag_b = b_neg ? -bus.op_b : bus.op_b;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .div_i    (op_is_div(op_q)),
        .acc_hi_o (acc_hi_d),
        .acc_lo_o (acc_lo_d)
    );

    always_comb begin
        prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix = neg_quo_q ? -prod : prod;
        quo_fix  = neg_quo_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_rem_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
        // divisor magnitude is zero exactly when the raw divisor was zero
        div_zero = op_is_div(op_q) && (opnd_q == '0);

        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (div_zero) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // MTHI/MTLO only while not busy; an operation accepted on the
            // same edge overwrites HI/LO later in SIGN
            if (!busy_q && bus.hi_we) hi_q <= bus.wdata;
            if (!busy_q && bus.lo_we) lo_q <= bus.wdata;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q   <= ST_CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        op_q      <= op_in;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        a_raw_q   <= bus.op_a;
                        acc_hi_q  <= '0;
                        dbz_q     <= 1'b0;
                        if (op_is_div(op_in)) begin
                            acc_lo_q <= mag_a;
                            opnd_q   <= mag_b;
                        end else begin
                            acc_lo_q <= mag_b;
                            opnd_q   <= mag_a;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= div_zero;
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit sitting beside the EX-stage ALU.
- Takes the MULT/MULTU/DIV/DIVU work off the combinational datapath and owns the architectural HI/LO registers.
- Uses a start/busy/done handshake with the pipeline control. The pipeline stalls on busy and consumes HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation: 0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU.
- op_a  input  WIDTH  rs operand: multiplicand or dividend.
- op_b  input  WIDTH  rt operand: multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; pipeline must stall MFHI/MFLO/MULT/DIV.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  output  1  sticky per operation; set on a DIV/DIVU with op_b=0, cleared at the next accepted start.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
  - Reset applied mid-operation aborts it with no HI/LO update.
- FSM states:
  - IDLE: busy=0.
  - CALC: busy=1, 32 iterations.
  - SIGN: busy=1, one cycle.
  - DONE: busy=0, done=1, one cycle.
- Transitions:
  - IDLE or DONE with start=1 at edge N → CALC.
  - CALC with counter=WIDTH-1 → SIGN.
  - SIGN → DONE.
  - DONE with no start → IDLE.
- Latency: done is high in cycle N+34 (32 CALC + 1 SIGN + 1 DONE).
  - Fixed for all operands, including divide-by-zero.
  - Back-to-back starts accepted in DONE: the next result arrives 34 cycles later.
- Operand capture at accept:
  - op, op_a, op_b are latched; later input changes have no effect.
  - Signed ops (MULT, DIV): operands converted to magnitudes; result signs recorded as neg_q = a[msb]^b[msb] and neg_r = a[msb].
- Multiply: radix-2 shift-add on a 2*WIDTH accumulator, one bit per CALC cycle.
  - SIGN negates the 64-bit product if neg_q.
  - hi = product[63:32], lo = product[31:0].
- Divide: restoring, one quotient bit per CALC cycle; remainder register is WIDTH+1 bits.
  - SIGN negates the quotient if neg_q and the remainder if neg_r (truncating division).
  - lo = quotient, hi = remainder.
- Divide-by-zero (op_b=0, DIV or DIVU):
  - Iterations run, but SIGN forces lo=all-ones and hi=op_a as captured.
  - div_by_zero=1.
- Signed overflow (DIV, op_a=0x80000000, op_b=0xFFFFFFFF): lo=0x80000000, hi=0. No flag.
- HI/LO update rules:
  - HI/LO change only in SIGN, on rst_n, or via hi_we/lo_we.
  - hi_we/lo_we are honoured only when busy=0 and are ignored while busy.
  - hi_we and start in the same edge: the write takes effect, and the operation later overwrites HI/LO.
- start while busy=1: ignored (no queueing). done is never asserted without a preceding accepted start.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state enum;
  - the constants WIDTH=32 and LATENCY=34.
- One sub-module, muldiv_step: purely combinational single iteration.
  - Conditional add for multiply, trial subtract for divide.
  - Takes accumulator, operand and op class; returns the next accumulator.
- Top level keeps the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=7 → done at cycle N+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles N+1..N+33.
- MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then DIVU 100/7 started in the DONE cycle → lo=14, hi=2 exactly 34 cycles later.
- DIVU op_a=0x12345678, op_b=0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; the next start clears div_by_zero.
- start with MULT 5×5, hi_we=1 with wdata=0xAA at cycle N+10 (busy), rst_n=0 at cycle N+20 → the write is ignored; reset gives hi=lo=0, busy=0, and no done pulse.
- IDLE: hi_we=1, lo_we=1, wdata=0x55 → hi=lo=0x55 next cycle, no done; then DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
